// File: rtl/countdown_ctrl_pkg.sv
// countdown_ctrl_pkg
//   Definitions shared by the countdown timer blocks (controller, display,
//   buzzer): state codes, the STATE bus width and a SEL width helper.
package countdown_ctrl_pkg;

  localparam int STATE_W = 3;

  // Codes are visible on the STATE output, so the values are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SET   = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_t;

  // Width of the digit-select bus; never narrower than one bit.
  function automatic int sel_width(input int n_stages);
    return (n_stages > 1) ? $clog2(n_stages) : 1;
  endfunction

endpackage

// File: rtl/cd_ce_chain.sv
// cd_ce_chain
//   Combinational cascade of count enables for a chain of down-counting
//   digit stages. Stage i counts when the tick is enabled and every lower
//   stage is at zero (it is about to borrow from stage i).
// Ports
//   tick  in  1         count-rate pulse
//   zero  in  N_STAGES  per-stage "value is zero" flags
//   en    in  1         global enable for the cascade
//   ce    out N_STAGES  per-stage count enables
module cd_ce_chain #(
  parameter int N_STAGES = 4
) (
  input  logic                tick,
  input  logic [N_STAGES-1:0] zero,
  input  logic                en,
  output logic [N_STAGES-1:0] ce
);

  logic carry;

  // NOTE: every variable written here gets a value before any branch or loop,
  // so no path can leave it holding its old value and infer a latch.
  always_comb begin
    ce    = '0;
    carry = tick & en;
    for (int i = 0; i < N_STAGES; i++) begin
      ce[i] = carry;
      carry = carry & zero[i];
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// countdown_ctrl
//   Mode and sequencing controller for the countdown timer's digit-counter
//   chain: digit setting, run, pause and alarm. Drives one count enable per
//   digit stage and a shared counter clear.
// Ports
//   CLK        in  1         system clock, rising edge
//   CLR_N      in  1         asynchronous active-low reset
//   TICK       in  1         1 Hz count pulse
//   BTN_START  in  1         start / pause / acknowledge pulse
//   BTN_MODE   in  1         enter SET / advance selected digit pulse
//   BTN_ADJ    in  1         step selected digit down pulse
//   BTN_RESET  in  1         clear counters pulse
//   ZERO       in  N_STAGES  per-stage zero flags
//   CE_O       out N_STAGES  per-stage count enables (combinational)
//   CNT_CLR    out 1         registered one-cycle clear to all stages
//   SEL        out SEL_W     digit selected in SET, 0 elsewhere
//   RUNNING    out 1         high in RUN
//   ALARM      out 1         high in ALARM
//   STATE      out 3         current state code
module countdown_ctrl
  import countdown_ctrl_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int ALARM_TICKS = 10,
  parameter int SEL_W       = sel_width(N_STAGES)
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic                TICK,
  input  logic                BTN_START,
  input  logic                BTN_MODE,
  input  logic                BTN_ADJ,
  input  logic                BTN_RESET,
  input  logic [N_STAGES-1:0] ZERO,
  output logic [N_STAGES-1:0] CE_O,
  output logic                CNT_CLR,
  output logic [SEL_W-1:0]    SEL,
  output logic                RUNNING,
  output logic                ALARM,
  output logic [STATE_W-1:0]  STATE
);

  localparam int CNT_W = $clog2(ALARM_TICKS + 1);

  state_t            state;
  logic [SEL_W-1:0]  sel;
  logic [CNT_W-1:0]  alarm_cnt;
  logic              cnt_clr;

  logic              all_zero;
  logic              adj_act;
  logic [N_STAGES-1:0] run_ce;

  assign all_zero = &ZERO;
  // ADJ only acts when no higher-priority button pulses in the same cycle.
  assign adj_act  = BTN_ADJ & ~BTN_RESET & ~BTN_START & ~BTN_MODE;

  // Cascade is disabled once the whole count is zero: the final tick raises
  // the alarm instead of wrapping the digits.
  cd_ce_chain #(
    .N_STAGES (N_STAGES)
  ) u_ce_chain (
    .tick (TICK),
    .zero (ZERO),
    .en   (~all_zero),
    .ce   (run_ce)
  );

  // Enables reach the stages in the same cycle; CLR_N gates them so nothing
  // counts while reset is held.
  always_comb begin
    CE_O = '0;
    if (CLR_N) begin
      case (state)
        ST_RUN:  CE_O = run_ce;
        ST_SET:  if (adj_act) CE_O[sel] = 1'b1;
        default: CE_O = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state     <= ST_IDLE;
      sel       <= '0;
      alarm_cnt <= '0;
      cnt_clr   <= 1'b0;
    end else begin
      cnt_clr <= 1'b0;
      if (BTN_RESET) begin
        state     <= ST_IDLE;
        sel       <= '0;
        alarm_cnt <= '0;
        cnt_clr   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            // A START on an all-zero count is swallowed; MODE does not act.
            if (BTN_START) begin
              if (!all_zero) state <= ST_RUN;
            end else if (BTN_MODE) begin
              state <= ST_SET;
              sel   <= '0;
            end
          end
          ST_SET: begin
            if (BTN_START) begin
              if (!all_zero) begin
                state <= ST_RUN;
                sel   <= '0;
              end
            end else if (BTN_MODE) begin
              if (sel == SEL_W'(N_STAGES - 1)) begin
                state <= ST_IDLE;
                sel   <= '0;
              end else begin
                sel <= sel + SEL_W'(1);
              end
            end
          end
          ST_RUN: begin
            // A TICK alongside START still counts through CE_O this cycle.
            if (BTN_START) begin
              state <= ST_PAUSE;
            end else if (TICK && all_zero) begin
              state     <= ST_ALARM;
              alarm_cnt <= CNT_W'(ALARM_TICKS - 1);
            end
          end
          ST_PAUSE: begin
            if (BTN_START) state <= all_zero ? ST_IDLE : ST_RUN;
          end
          ST_ALARM: begin
            if (BTN_START) begin
              state     <= ST_IDLE;
              alarm_cnt <= '0;
              cnt_clr   <= 1'b1;
            end else if (TICK) begin
              if (alarm_cnt == '0) begin
                state   <= ST_IDLE;
                cnt_clr <= 1'b1;
              end else begin
                alarm_cnt <= alarm_cnt - CNT_W'(1);
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            sel   <= '0;
          end
        endcase
      end
    end
  end

  // Status outputs are direct decodes of registered state.
  assign CNT_CLR = cnt_clr;
  assign SEL     = sel;
  assign RUNNING = (state == ST_RUN);
  assign ALARM   = (state == ST_ALARM);
  assign STATE   = state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb_countdown_ctrl
//   Self-checking bench for countdown_ctrl: directed scenarios followed by
//   randomized button/tick/zero traffic, compared against a behavioural
//   model of the controller's mode rules.
module tb_countdown_ctrl;

  localparam int N  = 4;
  localparam int AT = 10;

  localparam int M_IDLE  = 0;
  localparam int M_SET   = 1;
  localparam int M_RUN   = 2;
  localparam int M_PAUSE = 3;
  localparam int M_ALARM = 4;

  logic         CLK = 1'b0;
  logic         CLR_N;
  logic         TICK, BTN_START, BTN_MODE, BTN_ADJ, BTN_RESET;
  logic [N-1:0] ZERO;
  logic [N-1:0] CE_O;
  logic         CNT_CLR;
  logic [1:0]   SEL;
  logic         RUNNING, ALARM;
  logic [2:0]   STATE;

  countdown_ctrl #(
    .N_STAGES    (N),
    .ALARM_TICKS (AT)
  ) dut (
    .CLK       (CLK),
    .CLR_N     (CLR_N),
    .TICK      (TICK),
    .BTN_START (BTN_START),
    .BTN_MODE  (BTN_MODE),
    .BTN_ADJ   (BTN_ADJ),
    .BTN_RESET (BTN_RESET),
    .ZERO      (ZERO),
    .CE_O      (CE_O),
    .CNT_CLR   (CNT_CLR),
    .SEL       (SEL),
    .RUNNING   (RUNNING),
    .ALARM     (ALARM),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: mode, selected digit, alarm ticks remaining, clear pulse.
  int m_state = M_IDLE;
  int m_sel   = 0;
  int m_left  = 0;
  bit m_clr   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // In RUN a tick decrements the whole multi-digit number: the least
  // significant stage always steps, and each run of zero digits from the
  // bottom borrows one further stage.
  function automatic logic [N-1:0] exp_ce(input bit t, s, m, a, r,
                                          input logic [N-1:0] z);
    logic [N-1:0] ce;
    int           k;
    ce = '0;
    if (m_state == M_RUN && t && z != '1) begin
      k = 0;
      while (z[k]) k++;
      ce = N'((1 << (k + 1)) - 1);
    end else if (m_state == M_SET && a && !r && !s && !m) begin
      ce[m_sel] = 1'b1;
    end
    return ce;
  endfunction

  task automatic model_next(input bit t, s, m, a, r, input logic [N-1:0] z);
    bit az;
    az    = (z == '1);
    m_clr = 1'b0;
    if (r) begin
      m_state = M_IDLE; m_sel = 0; m_left = 0; m_clr = 1'b1;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (s) begin
            if (!az) m_state = M_RUN;
          end else if (m) begin
            m_state = M_SET; m_sel = 0;
          end
        end
        M_SET: begin
          if (s) begin
            if (!az) begin m_state = M_RUN; m_sel = 0; end
          end else if (m) begin
            if (m_sel == N - 1) begin m_state = M_IDLE; m_sel = 0; end
            else m_sel++;
          end
        end
        M_RUN: begin
          if (s) m_state = M_PAUSE;
          else if (t && az) begin m_state = M_ALARM; m_left = AT; end
        end
        M_PAUSE: if (s) m_state = az ? M_IDLE : M_RUN;
        M_ALARM: begin
          // m_left counts the ticks still needed to leave ALARM.
          if (s) begin m_state = M_IDLE; m_clr = 1'b1; m_left = 0; end
          else if (t) begin
            m_left--;
            if (m_left == 0) begin m_state = M_IDLE; m_clr = 1'b1; end
          end
        end
        default: m_state = M_IDLE;
      endcase
    end
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".state"},   32'(STATE),   32'(m_state));
    check({tag, ".sel"},     32'(SEL),     32'(m_sel));
    check({tag, ".running"}, 32'(RUNNING), 32'(m_state == M_RUN));
    check({tag, ".alarm"},   32'(ALARM),   32'(m_state == M_ALARM));
    check({tag, ".cnt_clr"}, 32'(CNT_CLR), 32'(m_clr));
  endtask

  // One clock cycle: drive inputs, check the combinational enables, then
  // check registered outputs just after the edge.
  task automatic step(input string tag, input bit t, s, m, a, r,
                      input logic [N-1:0] z);
    TICK = t; BTN_START = s; BTN_MODE = m; BTN_ADJ = a; BTN_RESET = r; ZERO = z;
    #1;
    check({tag, ".ce"}, 32'(CE_O), 32'(exp_ce(t, s, m, a, r, z)));
    model_next(t, s, m, a, r, z);
    @(posedge CLK);
    #1;
    check_regs(tag);
  endtask

  initial begin
    CLR_N = 1'b0;
    TICK = 0; BTN_START = 0; BTN_MODE = 0; BTN_ADJ = 0; BTN_RESET = 0;
    ZERO = '0;

    // Reset state, with a tick present to confirm enables stay low.
    #12;
    TICK = 1'b1;
    #1;
    check("rst.ce", 32'(CE_O), 32'd0);
    check_regs("rst");
    TICK = 1'b0;
    #9;
    CLR_N = 1'b1;
    @(posedge CLK);
    #1;

    // Digit setting: three single-cycle adjusts of digit 0, then walk SEL out.
    step("set.mode", 0, 0, 1, 0, 0, 4'b0000);
    for (int i = 0; i < 3; i++) step("set.adj", 0, 0, 0, 1, 0, 4'b0000);
    step("set.quiet", 0, 0, 0, 0, 0, 4'b0000);
    for (int i = 0; i < N; i++) step("set.walk", 0, 0, 1, 0, 0, 4'b0000);
    check("set.back_idle", 32'(STATE), 32'd0);

    // Run cascade.
    step("run.start", 0, 1, 0, 0, 0, 4'b0011);
    step("run.c0111", 1, 0, 0, 0, 0, 4'b0011);
    step("run.notick", 0, 0, 0, 0, 0, 4'b0011);
    step("run.c0001", 1, 0, 0, 0, 0, 4'b0000);

    // Expiry and alarm duration, with idle cycles between ticks.
    step("exp.tick", 1, 0, 0, 0, 0, 4'b1111);
    check("exp.in_alarm", 32'(ALARM), 32'd1);
    for (int i = 0; i < AT; i++) begin
      step("exp.gap", 0, 0, 0, 0, 0, 4'b1111);
      step("exp.atick", 1, 0, 0, 0, 0, 4'b1111);
    end
    check("exp.idle", 32'(STATE), 32'd0);
    step("exp.after", 0, 0, 0, 0, 0, 4'b1111);

    // Pause boundaries.
    step("pb.start", 0, 1, 0, 0, 0, 4'b0001);
    step("pb.start_tick", 1, 1, 0, 0, 0, 4'b0001);
    step("pb.paused_tick", 1, 0, 0, 0, 0, 4'b0001);
    step("pb.pause_zero", 0, 1, 0, 0, 0, 4'b1111);
    step("pb.idle_zero", 0, 1, 0, 0, 0, 4'b1111);

    // Priority: RESET beats START in RUN.
    step("pr.start", 0, 1, 0, 0, 0, 4'b0100);
    step("pr.reset", 1, 1, 0, 0, 1, 4'b0100);

    // Asynchronous reset in the middle of ALARM.
    step("ar.start", 0, 1, 0, 0, 0, 4'b0010);
    step("ar.expire", 1, 0, 0, 0, 0, 4'b1111);
    step("ar.atick", 1, 0, 0, 0, 0, 4'b1111);
    TICK = 1'b1; ZERO = 4'b1111; CLR_N = 1'b0;
    #1;
    m_state = M_IDLE; m_sel = 0; m_left = 0; m_clr = 1'b0;
    check("ar.ce", 32'(CE_O), 32'd0);
    check_regs("ar");
    @(posedge CLK);
    #1;
    CLR_N = 1'b1; TICK = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit t, s, m, a, r;
      logic [N-1:0] z;
      t = ($urandom_range(0, 2) == 0);
      s = ($urandom_range(0, 11) == 0);
      m = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 4) == 0);
      r = ($urandom_range(0, 79) == 0);
      z = ($urandom_range(0, 3) == 0) ? '1 : N'($urandom);
      step("rnd", t, s, m, a, r, z);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
